// File: rtl/gate_sweep_pkg.sv
// Shared types, mode encodings and vector-count helper for the gate sweeper.
package gate_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } sweep_state_e;

   localparam logic [1:0] MODE_BIN  = 2'd0;
   localparam logic [1:0] MODE_GRAY = 2'd1;
   localparam logic [1:0] MODE_WALK = 2'd2;

   // Number of vectors in a sweep: one per input bit when walking a one,
   // otherwise every combination (the reserved mode behaves as binary).
   function automatic logic [16:0] nvec(input int unsigned n_in, input logic [1:0] mode);
      if (mode == MODE_WALK) begin
         return 17'(n_in);
      end else begin
         return 17'd1 << n_in;
      end
   endfunction

endpackage

// File: rtl/sweep_vector_encoder.sv
// Maps a sweep index to the stimulus vector for the selected sweep mode.
module sweep_vector_encoder
   import gate_sweep_pkg::*;
#(
   parameter int N_IN = 9
) (
   input  logic [N_IN-1:0] index_i,
   input  logic [1:0]      mode_i,
   output logic [N_IN-1:0] vec_o
);

   localparam logic [N_IN-1:0] ONE = N_IN'(1);

   // Select binary, Gray or walking-one encoding of the index.
   always_comb begin
      vec_o = index_i;
      case (mode_i)
         MODE_GRAY: vec_o = index_i ^ (index_i >> 1);
         MODE_WALK: vec_o = ONE << index_i;
         default:   vec_o = index_i;
      endcase
   end

endmodule

// File: rtl/gate_vector_sweeper.sv
// Exhaustive stimulus generator and response checker for N-input gate DUTs.
// Every output is registered, so it reflects the FSM state of the previous cycle.
module gate_vector_sweeper
   import gate_sweep_pkg::*;
#(
   parameter int N_IN   = 9,
   parameter int N_OUT  = 5,
   parameter int SETTLE = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [1:0]       mode_i,
   output logic [N_IN-1:0]  stim_o,
   input  logic [N_OUT-1:0] resp_i,
   input  logic [N_OUT-1:0] expect_i,
   output logic             busy_o,
   output logic             chk_valid_o,
   output logic             chk_fail_o,
   output logic [N_IN:0]    vec_index_o,
   output logic             done_o,
   output logic [N_IN:0]    err_count_o,
   output logic [N_IN-1:0]  first_err_vec_o,
   output logic             first_err_valid_o
);

   localparam int VW = N_IN + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   sweep_state_e    state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [VW-1:0]   vec_q, vec_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic            busy_q, busy_d;
   logic            chk_valid_q, chk_valid_d;
   logic            chk_fail_q, chk_fail_d;
   logic            done_q, done_d;
   logic [VW-1:0]   err_q, err_d;
   logic [N_IN-1:0] fev_q, fev_d;
   logic            fevv_q, fevv_d;

   logic [N_IN-1:0] enc_s;
   logic [VW-1:0]   last_idx_s;
   logic            mism_s;

   sweep_vector_encoder #(.N_IN(N_IN)) u_enc (
      .index_i (vec_q[N_IN-1:0]),
      .mode_i  (mode_q),
      .vec_o   (enc_s)
   );

   assign last_idx_s = VW'(nvec(N_IN, mode_q) - 17'd1);
   assign mism_s     = (resp_i != expect_i);

   // Next-state and registered-output decode for the sweep FSM.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      stim_d      = stim_q;
      busy_d      = 1'b0;
      chk_valid_d = 1'b0;
      chk_fail_d  = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;
      fev_d       = fev_q;
      fevv_d      = fevv_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               mode_d  = mode_i;
               err_d   = '0;
               fevv_d  = 1'b0;
               vec_d   = '0;
               state_d = ST_APPLY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_APPLY: begin
            busy_d = ~abort_i;
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               stim_d  = enc_s;
               cnt_d   = CW'(SETTLE - 1);
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            busy_d = ~abort_i;
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_CHECK: begin
            // The compare is recorded even when the sweep is aborted here.
            busy_d      = ~abort_i;
            chk_valid_d = 1'b1;
            chk_fail_d  = mism_s;
            if (mism_s) begin
               err_d = err_q + VW'(1);
               if (!fevv_q) begin
                  fev_d  = stim_q;
                  fevv_d = 1'b1;
               end else begin
                  fev_d  = fev_q;
               end
            end else begin
               err_d = err_q;
            end
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (vec_q == last_idx_s) begin
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + VW'(1);
               state_d = ST_APPLY;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_BIN;
         vec_q       <= '0;
         cnt_q       <= '0;
         stim_q      <= '0;
         busy_q      <= 1'b0;
         chk_valid_q <= 1'b0;
         chk_fail_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
         fev_q       <= '0;
         fevv_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         stim_q      <= stim_d;
         busy_q      <= busy_d;
         chk_valid_q <= chk_valid_d;
         chk_fail_q  <= chk_fail_d;
         done_q      <= done_d;
         err_q       <= err_d;
         fev_q       <= fev_d;
         fevv_q      <= fevv_d;
      end
   end

   assign stim_o            = stim_q;
   assign busy_o            = busy_q;
   assign chk_valid_o       = chk_valid_q;
   assign chk_fail_o        = chk_fail_q;
   assign vec_index_o       = vec_q;
   assign done_o            = done_q;
   assign err_count_o       = err_q;
   assign first_err_vec_o   = fev_q;
   assign first_err_valid_o = fevv_q;

endmodule

// File: tb/tb_gate_vector_sweeper.sv
// Bench for gate_vector_sweeper: a 9-input OR gate as DUT (table-driven sweeps,
// scoreboard on every compare) plus a 3-input instance with a longer settle window.
module tb_gate_vector_sweeper;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic [1:0] mode_i = 2'd0;
   logic [8:0] stim_o;
   logic [4:0] resp_s, expect_s;
   logic       busy_o, chk_valid_o, chk_fail_o, done_o, first_err_valid_o;
   logic [9:0] vec_index_o, err_count_o;
   logic [8:0] first_err_vec_o;

   logic       start3 = 1'b0;
   logic       abort3 = 1'b0;
   logic [1:0] mode3 = 2'd1;
   logic [2:0] stim3;
   logic       resp3 = 1'b0;
   logic       expect3 = 1'b0;
   logic       busy3, chk_valid3, chk_fail3, done3, fevv3;
   logic [3:0] vec_index3, err_count3;
   logic [2:0] fev3;

   int n_vec = 0;
   int n_miss = 0;
   int bad0 = -1;
   int bad1 = -1;

   typedef struct {
      logic [8:0] stim;
      logic       fail;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [1:0] mode;
      int         bad0;
      int         bad1;
      int         exp_err;
      logic [8:0] exp_fev;
      logic       exp_fevv;
      int         exp_cycles;
   } sweep_vec_t;
   sweep_vec_t tbl [7];

   always #5 clk = ~clk;

   // Golden OR gate; the expectation is forced to zero at the chosen bad indices.
   assign resp_s   = {4'd0, |stim_o};
   assign expect_s = ((int'(vec_index_o) == bad0) || (int'(vec_index_o) == bad1)) ? 5'd0 : {4'd0, |stim_o};

   gate_vector_sweeper #(.N_IN(9), .N_OUT(5), .SETTLE(1)) u_dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
      .stim_o(stim_o), .resp_i(resp_s), .expect_i(expect_s), .busy_o(busy_o),
      .chk_valid_o(chk_valid_o), .chk_fail_o(chk_fail_o), .vec_index_o(vec_index_o),
      .done_o(done_o), .err_count_o(err_count_o), .first_err_vec_o(first_err_vec_o),
      .first_err_valid_o(first_err_valid_o)
   );

   gate_vector_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start3), .abort_i(abort3), .mode_i(mode3),
      .stim_o(stim3), .resp_i(resp3), .expect_i(expect3), .busy_o(busy3),
      .chk_valid_o(chk_valid3), .chk_fail_o(chk_fail3), .vec_index_o(vec_index3),
      .done_o(done3), .err_count_o(err_count3), .first_err_vec_o(fev3),
      .first_err_valid_o(fevv3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] model_enc(input int i, input logic [1:0] m);
      case (m)
         2'd1:    return 9'(i ^ (i >> 1));
         2'd2:    return 9'(1 << i);
         default: return 9'(i);
      endcase
   endfunction

   function automatic int model_nvec(input logic [1:0] m);
      return (m == 2'd2) ? 9 : 512;
   endfunction

   // Scoreboard: every compare pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst_i && chk_valid_o) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_unexpected: got chk_valid with stim %0d, expected no compare", stim_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_stim", 32'(stim_o), 32'(e.stim));
            chk("sb_fail", 32'(chk_fail_o), 32'(e.fail));
         end
      end
   end

   task automatic push_exp(input logic [1:0] m, input int count);
      for (int i = 0; i < count; i++) begin
         sb_q.push_back('{model_enc(i, m), (i == bad0) || (i == bad1)});
      end
   endtask

   task automatic kick(input logic [1:0] m);
      @(negedge clk);
      mode_i  = m;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      mode_i  = ~m;
   endtask

   task automatic run_sweep(input sweep_vec_t v);
      int cyc;
      bit got;
      bad0 = v.bad0;
      bad1 = v.bad1;
      push_exp(v.mode, model_nvec(v.mode));
      kick(v.mode);
      chk("busy_at_start_edge", 32'(busy_o), 32'd0);
      cyc = 0;
      got = 1'b0;
      while (cyc < v.exp_cycles + 20 && !got) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) begin
            chk("busy_after_apply", 32'(busy_o), 32'd1);
         end
         if (cyc == 10) start_i = 1'b1;
         if (cyc == 11) start_i = 1'b0;
         if (done_o) got = 1'b1;
      end
      chk("done_cycle", 32'(cyc), 32'(v.exp_cycles));
      chk("err_count", 32'(err_count_o), 32'(v.exp_err));
      chk("first_err_valid", 32'(first_err_valid_o), 32'(v.exp_fevv));
      if (v.exp_fevv) chk("first_err_vec", 32'(first_err_vec_o), 32'(v.exp_fev));
      chk("vec_index_last", 32'(vec_index_o), 32'(model_nvec(v.mode) - 1));
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("busy_after_done", 32'(busy_o), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_stim"}, 32'(stim_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_chk_valid"}, 32'(chk_valid_o), 32'd0);
      chk({tag, "_chk_fail"}, 32'(chk_fail_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_vec_index"}, 32'(vec_index_o), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count_o), 32'd0);
      chk({tag, "_fev"}, 32'(first_err_vec_o), 32'd0);
      chk({tag, "_fevv"}, 32'(first_err_valid_o), 32'd0);
   endtask

   initial begin
      logic [2:0] gray_seq [8];
      int cyc;
      int j;
      int dones;

      tbl[0] = '{2'd0, -1,  -1, 0, 9'd0, 1'b0, 1537};
      tbl[1] = '{2'd1, -1,  -1, 0, 9'd0, 1'b0, 1537};
      tbl[2] = '{2'd2, -1,  -1, 0, 9'd0, 1'b0, 28};
      tbl[3] = '{2'd3, -1,  -1, 0, 9'd0, 1'b0, 1537};
      tbl[4] = '{2'd0,  5, 200, 2, 9'd5, 1'b1, 1537};
      tbl[5] = '{2'd1,  5, 200, 2, 9'd7, 1'b1, 1537};
      tbl[6] = '{2'd2,  3,  -1, 1, 9'd8, 1'b1, 28};
      gray_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      check_reset_outputs("reset");

      // Abort during SETTLE of vector 3, with a mismatch already recorded at vector 1.
      bad0 = 1;
      bad1 = -1;
      push_exp(2'd0, 3);
      kick(2'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_pre_busy", 32'(busy_o), 32'd1);
      chk("abort_pre_stim", 32'(stim_o), 32'd3);
      abort_i = 1'b1;
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_stim_held", 32'(stim_o), 32'd3);
      chk("abort_err_held", 32'(err_count_o), 32'd1);
      chk("abort_fev", 32'(first_err_vec_o), 32'd1);
      chk("abort_fevv", 32'(first_err_valid_o), 32'd1);
      chk("abort_sb_drained", 32'(sb_q.size()), 32'd0);
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (done_o) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);

      // Table of full sweeps; the first one also shows the restart after abort.
      for (int t = 0; t < 7; t++) begin
         run_sweep(tbl[t]);
      end

      // Reset asserted while vector 2 is in CHECK.
      bad0 = 1;
      bad1 = -1;
      push_exp(2'd0, 2);
      kick(2'd0);
      repeat (8) @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      check_reset_outputs("midrst");
      chk("midrst_sb_drained", 32'(sb_q.size()), 32'd0);
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (done_o || busy_o) dones++;
      end
      chk("midrst_stays_idle", 32'(dones), 32'd0);

      // 3-input Gray sweep with a three-cycle settle window: 1 + 8*5 cycles.
      @(negedge clk);
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      mode3 = 2'd0;
      cyc = 0;
      j = 0;
      while (cyc < 80 && !done3) begin
         @(posedge clk);
         cyc++;
         #1;
         if (chk_valid3) begin
            if (j < 8) chk("gray3_stim", 32'(stim3), 32'(gray_seq[j]));
            j++;
         end
      end
      chk("gray3_compares", 32'(j), 32'd8);
      chk("gray3_done_cycle", 32'(cyc), 32'd41);
      chk("gray3_err", 32'(err_count3), 32'd0);
      chk("gray3_fevv", 32'(fevv3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
